// File: rtl/store_unit.sv
// Store path: aligns SB/SH/SW data to byte lanes and drives a valid/ready word write bus.
// Optional feature macro: STORE_MISALIGNED_SPLIT_EN (misaligned stores split into two beats).
module store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_FUNCT3   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [31:0]      b1_addr_q, b1_addr_d;
    logic [31:0]      b1_wdata_q, b1_wdata_d;
    logic [3:0]       b1_wstrb_q, b1_wstrb_d;

    logic [1:0]  off;
    logic [3:0]  mask;
    logic [31:0] byte_mask;
    logic        bad_funct3;
    logic        misaligned;
    logic [7:0]  strb8;
    logic [63:0] data64;
    logic [31:0] word_addr;
    logic        timeout_hit;

    // Lane alignment of the incoming request
    always_comb begin
        off        = addr[1:0];
        mask       = 4'b0000;
        byte_mask  = '0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000: begin
                mask      = 4'b0001;
                byte_mask = 32'h0000_00FF;
            end
            3'b001: begin
                mask      = 4'b0011;
                byte_mask = 32'h0000_FFFF;
            end
            3'b010: begin
                mask      = 4'b1111;
                byte_mask = '1;
            end
            default: bad_funct3 = 1'b1;
        endcase
        strb8     = {4'b0000, mask} << off;
        data64    = {32'b0, wdata & byte_mask} << {off, 3'b000};
        word_addr = {addr[31:2], 2'b00};
`ifdef STORE_MISALIGNED_SPLIT_EN
        misaligned = 1'b0;
`else
        misaligned = ((funct3 == 3'b001) && off[0]) ||
                     ((funct3 == 3'b010) && (off != 2'b00));
`endif
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            b1_addr_q   <= '0;
            b1_wdata_q  <= '0;
            b1_wstrb_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            b1_addr_q   <= b1_addr_d;
            b1_wdata_q  <= b1_wdata_d;
            b1_wstrb_q  <= b1_wstrb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        b1_addr_d   = b1_addr_q;
        b1_wdata_d  = b1_wdata_q;
        b1_wstrb_d  = b1_wstrb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_funct3) begin
                        err_d      = 1'b1;
                        err_code_d = CODE_FUNCT3;
                    end else if (misaligned) begin
                        err_d      = 1'b1;
                        err_code_d = CODE_MISALIGN;
                    end else begin
                        // Both beats are captured up front; an empty beat-1 strobe means single beat
                        state_d     = REQ0;
                        cnt_d       = '0;
                        mem_addr_d  = word_addr;
                        mem_wdata_d = data64[31:0];
                        mem_wstrb_d = strb8[3:0];
                        b1_addr_d   = word_addr + 32'd4;
                        b1_wdata_d  = data64[63:32];
                        b1_wstrb_d  = strb8[7:4];
                    end
                end
            end
            REQ0, REQ1: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if ((state_q == REQ0) && (b1_wstrb_q != 4'b0000)) begin
                        state_d     = REQ1;
                        mem_addr_d  = b1_addr_q;
                        mem_wdata_d = b1_wdata_q;
                        mem_wstrb_d = b1_wstrb_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = CODE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        mem_valid = (state_q == REQ0) || (state_q == REQ1);
        done      = done_q;
        err       = err_q;
        err_code  = err_code_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_wstrb = mem_wstrb_q;
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a byte-level transaction model checked every cycle.
module tb_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_ready = 1'b0;
    logic        busy, done, err, mem_valid;
    logic [1:0]  err_code;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
        .funct3(funct3), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    beat_t       mq[$];
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = '0;
    int unsigned m_wait = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: split the store into bytes, group bytes by word address into beats
    task automatic model_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned sz;
        logic [31:0] ba, wa;
        logic [1:0]  lane;
        beat_t       b;
        bit          mis;
        if (f3 > 3'd2) begin
            m_err  = 1'b1;
            m_code = 2'b10;
            return;
        end
        sz  = 32'd1 << f3;
        mis = (a % sz) != 0;
`ifdef STORE_MISALIGNED_SPLIT_EN
        mis = 1'b0;
`endif
        if (mis) begin
            m_err  = 1'b1;
            m_code = 2'b01;
            return;
        end
        m_wait = 0;
        b      = '0;
        b.a    = {a[31:2], 2'b00};
        for (int unsigned i = 0; i < sz; i++) begin
            ba   = a + 32'(i);
            wa   = {ba[31:2], 2'b00};
            lane = ba[1:0];
            if (wa != b.a) begin
                mq.push_back(b);
                b   = '0;
                b.a = wa;
            end
            b.s[lane]          = 1'b1;
            b.d[8*lane +: 8]   = d[8*i +: 8];
        end
        mq.push_back(b);
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            mq.delete();
            m_code = '0;
            m_wait = 0;
        end else if (mq.size() != 0) begin
            if (mem_ready) begin
                void'(mq.pop_front());
                m_wait = 0;
                if (mq.size() == 0) m_done = 1'b1;
            end else begin
                m_wait++;
                if (TO != 0 && m_wait == TO) begin
                    mq.delete();
                    m_err  = 1'b1;
                    m_code = 2'b11;
                    m_wait = 0;
                end
            end
        end else if (start) begin
            model_start(funct3, addr, wdata);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy", 32'(busy), 32'(mq.size() != 0));
            chk("mem_valid", 32'(mem_valid), 32'(mq.size() != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            if (mq.size() != 0) begin
                chk("mem_addr", mem_addr, mq[0].a);
                chk("mem_wdata", mem_wdata, mq[0].d);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(mq[0].s));
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy);
        @(negedge clk);
        start     = 1'b1;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        mem_ready = rdy;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic lit_beat(input string name, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        chk({name, " valid"}, 32'(mem_valid), 32'd1);
        chk({name, " addr"}, mem_addr, a);
        chk({name, " strb"}, 32'(mem_wstrb), 32'(s));
        chk({name, " wdata"}, mem_wdata, d);
    endtask

    initial begin
        int vc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst valid", 32'(mem_valid), 32'd0);
        chk("rst code", 32'(err_code), 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst strb", 32'(mem_wstrb), 32'd0);
        checking = 1'b1;
        rst      = 1'b0;

        // 1: SB single beat
        issue(3'b000, 32'h0000_1002, 32'hAABB_CCDD, 1'b1);
        lit_beat("t1", 32'h0000_1000, 4'b0100, 32'h00DD_0000);
        @(negedge clk);
        chk("t1 done", 32'(done), 32'd1);
        chk("t1 busy", 32'(busy), 32'd0);

        // 2: SH with three stall cycles
        issue(3'b001, 32'h0000_2002, 32'h0000_1234, 1'b0);
        lit_beat("t2 c1", 32'h0000_2000, 4'b1100, 32'h1234_0000);
        repeat (2) @(negedge clk);
        lit_beat("t2 c3", 32'h0000_2000, 4'b1100, 32'h1234_0000);
        @(negedge clk);
        mem_ready = 1'b1;
        lit_beat("t2 c4", 32'h0000_2000, 4'b1100, 32'h1234_0000);
        @(negedge clk);
        chk("t2 done", 32'(done), 32'd1);

        // 3: SW offset 1
        issue(3'b010, 32'h0000_3001, 32'h1122_3344, 1'b1);
`ifdef STORE_MISALIGNED_SPLIT_EN
        lit_beat("t3 b0", 32'h0000_3000, 4'b1110, 32'h2233_4400);
        @(negedge clk);
        lit_beat("t3 b1", 32'h0000_3004, 4'b0001, 32'h0000_0011);
        @(negedge clk);
        chk("t3 done", 32'(done), 32'd1);
`else
        chk("t3 err", 32'(err), 32'd1);
        chk("t3 code", 32'(err_code), 32'd1);
        chk("t3 valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        chk("t3 valid later", 32'(mem_valid), 32'd0);
`endif

        // 4: illegal funct3
        issue(3'b011, 32'h0000_0100, 32'h0, 1'b1);
        chk("t4 err", 32'(err), 32'd1);
        chk("t4 code", 32'(err_code), 32'd2);
        chk("t4 busy", 32'(busy), 32'd0);
        chk("t4 valid", 32'(mem_valid), 32'd0);

        // 5: timeout after TO waiting cycles
        issue(3'b010, 32'h0000_4000, 32'h5566_7788, 1'b0);
        vc = 0;
        while (mem_valid === 1'b1 && vc < 10) begin
            vc++;
            @(negedge clk);
        end
        chk("t5 valid cycles", 32'(vc), 32'(TO));
        chk("t5 err", 32'(err), 32'd1);
        chk("t5 code", 32'(err_code), 32'd3);
        chk("t5 done", 32'(done), 32'd0);

        // 6: reset during REQ0, then a clean SB
        issue(3'b000, 32'h0000_5000, 32'h0000_0077, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 valid", 32'(mem_valid), 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 done", 32'(done), 32'd0);
        chk("t6 err", 32'(err), 32'd0);
        issue(3'b000, 32'h0000_5003, 32'h0000_00EE, 1'b1);
        lit_beat("t6 sb", 32'h0000_5000, 4'b1000, 32'hEE00_0000);
        @(negedge clk);
        chk("t6 done2", 32'(done), 32'd1);

        // 7: start ignored while busy, accepted in the done cycle
        issue(3'b010, 32'h0000_6000, 32'hCAFE_F00D, 1'b0);
        start  = 1'b1;
        funct3 = 3'b011;
        addr   = 32'h0000_9999;
        @(negedge clk);
        chk("t7 no err", 32'(err), 32'd0);
        lit_beat("t7 hold", 32'h0000_6000, 4'b1111, 32'hCAFE_F00D);
        @(negedge clk);
        start     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t7 done", 32'(done), 32'd1);
        start  = 1'b1;
        funct3 = 3'b000;
        addr   = 32'h0000_7001;
        wdata  = 32'h0000_005A;
        @(negedge clk);
        start = 1'b0;
        lit_beat("t7 next", 32'h0000_7000, 4'b0010, 32'h0000_5A00);
        @(negedge clk);
        chk("t7 done2", 32'(done), 32'd1);

        // 8: SH offset 1 and SH at the top of the address space
        issue(3'b001, 32'h0000_8001, 32'h0000_ABCD, 1'b1);
`ifdef STORE_MISALIGNED_SPLIT_EN
        lit_beat("t8 sh1", 32'h0000_8000, 4'b0110, 32'h00AB_CD00);
        @(negedge clk);
        chk("t8 done", 32'(done), 32'd1);
        issue(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b1);
        lit_beat("t8 w0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        @(negedge clk);
        lit_beat("t8 w1", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
        @(negedge clk);
        chk("t8 wrap done", 32'(done), 32'd1);
`else
        chk("t8 err", 32'(err), 32'd1);
        chk("t8 code", 32'(err_code), 32'd1);
        issue(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b1);
        chk("t8 wrap err", 32'(err), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
